// File: rtl/anton_neopixel_bit_encoder.sv
// ============================================================================
// Module   : anton_neopixel_bit_encoder
// Purpose  : Fetches pixel bytes and shapes each bit into a WS2812 waveform.
//            Optional frame counter enabled by ANTON_NEOPIXEL_FRAME_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 63
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module anton_neopixel_bit_encoder #(
    parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int READ_LATENCY = 1,
    parameter int T0H_STEPS    = 2,
    parameter int T1H_STEPS    = 5,
    localparam int BUFFER_BITS = (BUFFER_END > 0) ? `CLOG2(BUFFER_END + 1) : 1
) (
    input  logic                   clk6_4mhz,
    input  logic                   rst,
    input  logic                   regCtrlInit,
    input  logic                   streamOutput,
    input  logic                   streamReset,
    input  logic [2:0]             bitPatternIndex,
    input  logic [2:0]             pixelBitIndex,
    input  logic [BUFFER_BITS-1:0] pixelIndexComb,
    output logic                   bufferRdEn,
    output logic [BUFFER_BITS-1:0] bufferRdAddr,
    input  logic [7:0]             bufferRdData,
    output logic                   neoData,
    output logic                   byteLoaded,
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    output logic [15:0]            frameCount,
`endif
    output logic                   readLateErr
);

    localparam logic [3:0] c_t0h_steps = 4'(T0H_STEPS);
    localparam logic [3:0] c_t1h_steps = 4'(T1H_STEPS);

    logic                    rd_en_q, rd_en_d;
    logic [BUFFER_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic [READ_LATENCY-1:0] valid_pipe_q, valid_pipe_d;
    logic [7:0]              shift_reg_q, shift_reg_d;
    logic                    neo_data_q, neo_data_d;
    logic                    byte_loaded_q, byte_loaded_d;
    logic                    read_late_err_q, read_late_err_d;
    logic                    fetch_pending_q, fetch_pending_d;

    logic                    byte_start;
    logic                    load;
    logic                    cur_bit;
    logic [3:0]              high_steps;

    always_comb begin
        byte_start = streamOutput && (pixelBitIndex == 3'd0) && (bitPatternIndex == 3'd0);
        load       = valid_pipe_q[READ_LATENCY-1];
        // Bypass the arriving byte so a load on the T0H step already shapes that step.
        cur_bit    = load ? bufferRdData[7] : shift_reg_q[7];
        high_steps = cur_bit ? c_t1h_steps : c_t0h_steps;

        rd_en_d         = byte_start;
        rd_addr_d       = byte_start ? pixelIndexComb : rd_addr_q;
        valid_pipe_d    = (valid_pipe_q << 1) | READ_LATENCY'(rd_en_q);
        byte_loaded_d   = load;
        shift_reg_d     = shift_reg_q;
        fetch_pending_d = fetch_pending_q;
        read_late_err_d = read_late_err_q;
        neo_data_d      = streamOutput && !streamReset
                          && ({1'b0, bitPatternIndex} < high_steps);

        if (load) begin
            shift_reg_d = bufferRdData;
        end else if (streamOutput && (bitPatternIndex == 3'd7)) begin
            shift_reg_d = {shift_reg_q[6:0], 1'b0};
        end

        if (byte_start) begin
            fetch_pending_d = 1'b1;
        end else if (load) begin
            fetch_pending_d = 1'b0;
        end

        if (streamOutput && (pixelBitIndex == 3'd0)
            && ({1'b0, bitPatternIndex} == c_t0h_steps)
            && fetch_pending_q && !load) begin
            read_late_err_d = 1'b1;
        end

        // Initialisation overrides every other event this clock.
        if (regCtrlInit) begin
            rd_en_d         = 1'b0;
            valid_pipe_d    = '0;
            byte_loaded_d   = 1'b0;
            shift_reg_d     = '0;
            fetch_pending_d = 1'b0;
            read_late_err_d = 1'b0;
            neo_data_d      = 1'b0;
        end
    end

    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst) begin
            rd_en_q         <= 1'b0;
            rd_addr_q       <= '0;
            valid_pipe_q    <= '0;
            shift_reg_q     <= '0;
            neo_data_q      <= 1'b0;
            byte_loaded_q   <= 1'b0;
            read_late_err_q <= 1'b0;
            fetch_pending_q <= 1'b0;
        end else begin
            rd_en_q         <= rd_en_d;
            rd_addr_q       <= rd_addr_d;
            valid_pipe_q    <= valid_pipe_d;
            shift_reg_q     <= shift_reg_d;
            neo_data_q      <= neo_data_d;
            byte_loaded_q   <= byte_loaded_d;
            read_late_err_q <= read_late_err_d;
            fetch_pending_q <= fetch_pending_d;
        end
    end

    assign bufferRdEn   = rd_en_q;
    assign bufferRdAddr = rd_addr_q;
    assign neoData      = neo_data_q;
    assign byteLoaded   = byte_loaded_q;
    assign readLateErr  = read_late_err_q;

`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    logic        stream_reset_prev_q, stream_reset_prev_d;
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        stream_reset_prev_d = streamReset;
        frame_count_d       = frame_count_q;
        if (regCtrlInit) begin
            frame_count_d = '0;
        end else if (streamReset && !stream_reset_prev_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst) begin
            stream_reset_prev_q <= 1'b0;
            frame_count_q       <= '0;
        end else begin
            stream_reset_prev_q <= stream_reset_prev_d;
            frame_count_q       <= frame_count_d;
        end
    end

    assign frameCount = frame_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_anton_neopixel_bit_encoder.sv
// ============================================================================
// Module   : tb_anton_neopixel_bit_encoder
// Purpose  : Self-checking bench for two encoder configurations sharing one
//            upstream stimulus (latency 1 / T0H 2 / T1H 5 and 2 / 3 / 6).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anton_neopixel_bit_encoder;

    localparam int BEND = 15;
    localparam int L_A = 1, T0_A = 2, T1_A = 5;
    localparam int L_B = 2, T0_B = 3, T1_B = 6;

    logic       clk = 1'b0;
    logic       rst, init, so, sr;
    logic [2:0] bpi, pbi;
    logic [3:0] idx;

    logic       rd_en_a, neo_a, loaded_a, err_a;
    logic       rd_en_b, neo_b, loaded_b, err_b;
    logic [3:0] rd_addr_a, rd_addr_b;
    logic [7:0] rd_data_a, rd_data_b, pipe_b;
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    logic [15:0] frame_a, frame_b;
`endif

    logic [7:0] mem [16];
    int  checks = 0;
    int  errors = 0;
    bit  err_exp_a = 1'b0;
    bit  err_exp_b = 1'b0;

    always #5 clk = ~clk;

    anton_neopixel_bit_encoder #(
        .BUFFER_END(BEND), .READ_LATENCY(L_A), .T0H_STEPS(T0_A), .T1H_STEPS(T1_A)
    ) dut_a (
        .clk6_4mhz(clk), .rst(rst), .regCtrlInit(init), .streamOutput(so),
        .streamReset(sr), .bitPatternIndex(bpi), .pixelBitIndex(pbi),
        .pixelIndexComb(idx), .bufferRdEn(rd_en_a), .bufferRdAddr(rd_addr_a),
        .bufferRdData(rd_data_a), .neoData(neo_a), .byteLoaded(loaded_a),
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
        .frameCount(frame_a),
`endif
        .readLateErr(err_a)
    );

    anton_neopixel_bit_encoder #(
        .BUFFER_END(BEND), .READ_LATENCY(L_B), .T0H_STEPS(T0_B), .T1H_STEPS(T1_B)
    ) dut_b (
        .clk6_4mhz(clk), .rst(rst), .regCtrlInit(init), .streamOutput(so),
        .streamReset(sr), .bitPatternIndex(bpi), .pixelBitIndex(pbi),
        .pixelIndexComb(idx), .bufferRdEn(rd_en_b), .bufferRdAddr(rd_addr_b),
        .bufferRdData(rd_data_b), .neoData(neo_b), .byteLoaded(loaded_b),
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
        .frameCount(frame_b),
`endif
        .readLateErr(err_b)
    );

    // Buffer memories: data outside a read slot is random so a mistimed load shows.
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? mem[rd_addr_a] : 8'($urandom);
        pipe_b    <= rd_en_b ? mem[rd_addr_b] : 8'($urandom);
        rd_data_b <= pipe_b;
    end

    // One sub-bit step of an upstream byte; v is the byte value the LED should see.
    task automatic do_step(input int k, input int s, input logic [7:0] v,
                           input bit fetch, input bit late, input int a);
        logic [3:0] exp_a, exp_b;
        bit bit_v;
        so = 1'b1; sr = 1'b0; pbi = 3'(k); bpi = 3'(s); idx = 4'(a);
        @(posedge clk); #1;
        bit_v = v[7-k];
        if (late && k == 0 && s == T0_A) err_exp_a = 1'b1;
        if (late && k == 0 && s == T0_B) err_exp_b = 1'b1;
        exp_a = {s < (bit_v ? T1_A : T0_A), fetch && k == 0 && s == 0,
                 fetch && !late && k == 0 && s == L_A + 1, err_exp_a};
        exp_b = {s < (bit_v ? T1_B : T0_B), fetch && k == 0 && s == 0,
                 fetch && !late && k == 0 && s == L_B + 1, err_exp_b};
        checks++;
        if ({neo_a, rd_en_a, loaded_a, err_a} !== exp_a) begin
            errors++;
            $display("FAIL step_a addr=%0d k=%0d s=%0d {neo,rden,ld,err} got %b exp %b",
                     a, k, s, {neo_a, rd_en_a, loaded_a, err_a}, exp_a);
        end
        checks++;
        if ({neo_b, rd_en_b, loaded_b, err_b} !== exp_b) begin
            errors++;
            $display("FAIL step_b addr=%0d k=%0d s=%0d {neo,rden,ld,err} got %b exp %b",
                     a, k, s, {neo_b, rd_en_b, loaded_b, err_b}, exp_b);
        end
        if (fetch && k == 0 && s == 0) begin
            checks++;
            if (rd_addr_a !== 4'(a) || rd_addr_b !== 4'(a)) begin
                errors++;
                $display("FAIL rd_addr got %0d/%0d exp %0d", rd_addr_a, rd_addr_b, a);
            end
        end
    endtask

    task automatic do_byte(input int a, input logic [7:0] v, input bit fetch,
                           input bit late, input int k0, input int s0);
        for (int k = k0; k < 8; k++)
            for (int s = (k == k0) ? s0 : 0; s < 8; s++)
                do_step(k, s, v, fetch, late, a);
    endtask

    task automatic test_reset();
        rst = 1'b1; init = 1'b0; so = 1'b0; sr = 1'b0; bpi = '0; pbi = '0; idx = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({neo_a, rd_en_a, loaded_a, err_a, rd_addr_a, neo_b, rd_en_b, loaded_b, err_b, rd_addr_b} !== '0) begin
            errors++;
            $display("FAIL reset_values got a=%b%b%b%b/%0d b=%b%b%b%b/%0d exp all 0",
                     neo_a, rd_en_a, loaded_a, err_a, rd_addr_a,
                     neo_b, rd_en_b, loaded_b, err_b, rd_addr_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            so = 1'b0; sr = 1'($urandom); bpi = 3'($urandom); pbi = 3'($urandom);
            idx = 4'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({neo_a, rd_en_a, neo_b, rd_en_b} !== 4'b0) begin
                errors++;
                $display("FAIL idle got neo/rden a=%b%b b=%b%b exp 0000",
                         neo_a, rd_en_a, neo_b, rd_en_b);
            end
        end
    endtask

    task automatic test_a5();
        int cnt_a, cnt_b, lds;
        int exp_cnt_a [8] = '{5, 2, 5, 2, 2, 5, 2, 5};
        int exp_cnt_b [8] = '{6, 3, 6, 3, 3, 6, 3, 6};
        mem[3] = 8'hA5;
        lds = 0;
        for (int k = 0; k < 8; k++) begin
            cnt_a = 0; cnt_b = 0;
            for (int s = 0; s < 8; s++) begin
                do_step(k, s, 8'hA5, 1'b1, 1'b0, 3);
                cnt_a += int'(neo_a);
                cnt_b += int'(neo_b);
                lds   += int'(loaded_a);
            end
            checks++;
            if (cnt_a != exp_cnt_a[k] || cnt_b != exp_cnt_b[k]) begin
                errors++;
                $display("FAIL a5_high_steps bit=%0d got %0d/%0d exp %0d/%0d",
                         k, cnt_a, cnt_b, exp_cnt_a[k], exp_cnt_b[k]);
            end
        end
        checks++;
        if (lds != 1) begin
            errors++;
            $display("FAIL a5_byte_loaded_pulses got %0d exp 1", lds);
        end
    endtask

    task automatic test_back_to_back();
        mem[4] = 8'h00;
        mem[5] = 8'hFF;
        do_byte(4, 8'h00, 1'b1, 1'b0, 0, 0);
        do_byte(5, 8'hFF, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        int a;
        a = 12 + int'($urandom_range(0, 3));
        for (int i = 0; i < 10; i++) begin
            mem[a] = 8'($urandom);
            do_byte(a, mem[a], 1'b1, 1'b0, 0, 0);
            a = (a + 1) % (BEND + 1);
            repeat ($urandom_range(0, 3)) begin
                so = 1'b0; bpi = 3'($urandom); pbi = 3'($urandom);
                @(posedge clk); #1;
                checks++;
                if ({neo_a, rd_en_a, neo_b, rd_en_b} !== 4'b0) begin
                    errors++;
                    $display("FAIL gap got neo/rden a=%b%b b=%b%b exp 0000",
                             neo_a, rd_en_a, neo_b, rd_en_b);
                end
            end
        end
    endtask

    task automatic test_reset_mid_bit();
        mem[7] = 8'hC3;
        for (int s = 0; s < 8; s++) do_step(0, s, 8'hC3, 1'b1, 1'b0, 7);
        do_step(1, 0, 8'hC3, 1'b1, 1'b0, 7);
        do_step(1, 1, 8'hC3, 1'b1, 1'b0, 7);
        rst = 1'b1;
        #1;
        checks++;
        if ({neo_a, rd_en_a, loaded_a, err_a, rd_addr_a, neo_b, rd_en_b, loaded_b, err_b, rd_addr_b} !== '0) begin
            errors++;
            $display("FAIL async_reset got a=%b%b%b%b/%0d b=%b%b%b%b/%0d exp all 0",
                     neo_a, rd_en_a, loaded_a, err_a, rd_addr_a,
                     neo_b, rd_en_b, loaded_b, err_b, rd_addr_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        err_exp_a = 1'b0; err_exp_b = 1'b0;
        do_byte(7, 8'h00, 1'b0, 1'b0, 1, 2);
        do_byte(8, mem[8], 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_late_err();
        force dut_a.valid_pipe_q = '0;
        force dut_b.valid_pipe_q = '0;
        do_byte(9, 8'h00, 1'b1, 1'b1, 0, 0);
        release dut_a.valid_pipe_q;
        release dut_b.valid_pipe_q;
        do_byte(10, mem[10], 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_init();
        mem[12] = 8'hFF;
        do_step(0, 0, 8'hFF, 1'b1, 1'b0, 12);
        do_step(0, 1, 8'hFF, 1'b1, 1'b0, 12);
        init = 1'b1; so = 1'b1; sr = 1'b0; pbi = 3'd0; bpi = 3'd2;
        @(posedge clk); #1;
        init = 1'b0;
        err_exp_a = 1'b0; err_exp_b = 1'b0;
        checks++;
        if ({neo_a, rd_en_a, loaded_a, err_a, neo_b, rd_en_b, loaded_b, err_b} !== 8'b0) begin
            errors++;
            $display("FAIL init_step got a=%b%b%b%b b=%b%b%b%b exp all 0",
                     neo_a, rd_en_a, loaded_a, err_a, neo_b, rd_en_b, loaded_b, err_b);
        end
        do_byte(12, 8'h00, 1'b0, 1'b0, 0, 3);
        do_byte(13, mem[13], 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_frame_count();
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
        so = 1'b0; sr = 1'b0; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (3) begin
            sr = 1'b1; repeat (2) @(posedge clk);
            #1;
            sr = 1'b0; repeat (2) @(posedge clk);
            #1;
        end
        checks++;
        if (frame_a !== 16'd3 || frame_b !== 16'd3) begin
            errors++;
            $display("FAIL frame_count got %0d/%0d exp 3", frame_a, frame_b);
        end
        force dut_a.frame_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut_a.frame_count_q;
        sr = 1'b1; @(posedge clk); #1;
        sr = 1'b0; @(posedge clk); #1;
        checks++;
        if (frame_a !== 16'h0000) begin
            errors++;
            $display("FAIL frame_wrap got %h exp 0000", frame_a);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i <= BEND; i++) mem[i] = 8'($urandom);
        test_reset();
        test_idle();
        test_a5();
        test_back_to_back();
        test_random();
        test_reset_mid_bit();
        test_late_err();
        test_init();
        test_frame_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
